// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite master: host cmd/rsp stream to AW+W+B or AR+R transactions.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_we,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                    aw_done_q, w_done_q;
  logic                    rsp_valid_q, rsp_we_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic                    aw_done_d, w_done_d, timeout_d;

  assign aw_done_d = aw_done_q | (awvalid_q & AWREADY);
  assign w_done_d  = w_done_q  | (wvalid_q  & WREADY);

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q;
  logic          active;

  assign active    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_REQ) || (state_q == RD_DATA);
  // Fires during the TIMEOUT_CYCLES-th active cycle so VALID/READY drop at that edge.
  assign timeout_d = active && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // IDLE is the only way into WR_REQ/RD_REQ, so clearing there clears on entry.
  always_ff @(posedge ACLK) begin
    if (ARESET)               tmo_cnt_q <= '0;
    else if (state_q == IDLE) tmo_cnt_q <= '0;
    else if (active)          tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign timeout_d = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q   <= cmd_addr;
          wdata_q  <= cmd_wdata;
          wstrb_q  <= cmd_wstrb;
          rsp_we_q <= cmd_we;
          if (cmd_we) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= WR_REQ;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= RD_REQ;
          end
        end
        WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (AWREADY) awvalid_q <= 1'b0;
          if (WREADY)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (BVALID) begin
          bready_q    <= 1'b0;
          rsp_resp_q  <= BRESP;
          rsp_rdata_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RD_REQ: if (ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (RVALID) begin
          rready_q    <= 1'b0;
          rsp_resp_q  <= RRESP;
          rsp_rdata_q <= RDATA;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Watchdog abort overrides any same-cycle progress.
      if (timeout_d) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rsp_resp_q  <= 2'b11;
        rsp_rdata_q <= '0;
        rsp_valid_q <= 1'b1;
        state_q     <= RSP;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = addr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = addr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: vector table + delay-configurable AXI-Lite slave + response scoreboard.
module tb_axil_master_bridge;
  localparam int AW = 32, DW = 32, SW = 4;

  logic          ACLK, ARESET;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  axil_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]    s_resp;
    logic [DW-1:0] s_rdata;
    int            hold;
    logic [1:0]    e_resp;
    logic [DW-1:0] e_rdata;
    int            e_lat;
  } vec_t;

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  // slave configuration and expected request fields
  int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]    s_resp;
  logic [DW-1:0] s_rdata;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [SW-1:0] cur_wstrb;
  logic          mon_off;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              input logic [SW-1:0] st, input int awd, input int wdl, input int bd,
                              input int ard, input int rd, input logic [1:0] sr,
                              input logic [DW-1:0] srd, input int hold, input logic [1:0] er,
                              input logic [DW-1:0] erd, input int lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.wstrb = st;
    v.aw_dly = awd; v.w_dly = wdl; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
    v.s_resp = sr; v.s_rdata = srd; v.hold = hold;
    v.e_resp = er; v.e_rdata = erd; v.e_lat = lat;
    return v;
  endfunction

  // Slave + protocol monitor. Runs on negedge: checks what happened at the last
  // posedge from saved values, then updates the READY/VALID it drives.
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic          p_awv = 0, p_wv = 0, p_arv = 0, p_br = 0, p_rr = 0;
  logic [AW-1:0] p_awaddr = 0, p_araddr = 0;
  logic [DW-1:0] p_wdata = 0;
  logic [SW-1:0] p_wstrb = 0;

  always @(negedge ACLK) begin
    if (!mon_off) begin
      if (p_awv && !AWREADY) begin
        chk("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
      end
      if (p_awv && AWREADY) chk("aw_addr", p_awaddr, cur_addr);
      if (p_wv && !WREADY) chk("w_hold", {WVALID, WSTRB, WDATA}, {1'b1, p_wstrb, p_wdata});
      if (p_wv && WREADY) chk("w_data", {p_wstrb, p_wdata}, {cur_wstrb, cur_wdata});
      if (p_arv && !ARREADY) chk("ar_hold", {ARVALID, ARADDR}, {1'b1, p_araddr});
      if (p_arv && ARREADY) chk("ar_addr", p_araddr, cur_addr);
      if (BREADY) chk("b_early", AWVALID | WVALID, 0);
      if (p_br && !BVALID) chk("bready_hold", BREADY, 1);
      if (p_rr && !RVALID) chk("rready_hold", RREADY, 1);
    end
    p_awv = AWVALID; p_wv = WVALID; p_arv = ARVALID; p_br = BREADY; p_rr = RREADY;
    p_awaddr = AWADDR; p_araddr = ARADDR; p_wdata = WDATA; p_wstrb = WSTRB;

    if (AWVALID) begin AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin AWREADY = 0; aw_cnt = 0; end
    if (WVALID) begin WREADY = (w_cnt >= w_dly); w_cnt++; end
    else begin WREADY = 0; w_cnt = 0; end
    if (ARVALID) begin ARREADY = (ar_cnt >= ar_dly); ar_cnt++; end
    else begin ARREADY = 0; ar_cnt = 0; end
    if (BREADY) begin BVALID = (b_cnt >= b_dly); b_cnt++; end
    else begin BVALID = 0; b_cnt = 0; end
    if (RREADY) begin RVALID = (r_cnt >= r_dly); r_cnt++; end
    else begin RVALID = 0; r_cnt = 0; end
    BRESP = s_resp; RRESP = s_resp; RDATA = s_rdata;
  end

  task automatic set_slave(input vec_t v);
    aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly; ar_dly = v.ar_dly; r_dly = v.r_dly;
    s_resp = v.s_resp; s_rdata = v.s_rdata;
    cur_addr = v.addr; cur_wdata = v.wdata; cur_wstrb = v.wstrb;
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_vec(input vec_t v, input string nm);
    int   n, lat;
    exp_t e;
    set_slave(v);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    chk({nm, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    sb.push_back('{we: v.we, rdata: v.e_rdata, resp: v.e_resp});
    @(negedge ACLK);
    cmd_valid = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin @(negedge ACLK); lat++; end
    chk({nm, "_latency"}, 64'(lat), 64'(v.e_lat));
    for (int h = 0; h < v.hold; h++) begin
      chk({nm, "_hold_valid"}, {rsp_valid, rsp_resp}, {1'b1, v.e_resp});
      chk({nm, "_hold_cmd_ready"}, cmd_ready, 0);
      @(negedge ACLK);
    end
    rsp_ready = 1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, "_rsp_we"}, rsp_we, e.we);
      chk({nm, "_rsp_rdata"}, rsp_rdata, e.rdata);
      chk({nm, "_rsp_resp"}, rsp_resp, e.resp);
    end
    @(negedge ACLK);
    rsp_ready = 0;
    chk({nm, "_b2b_ready"}, {cmd_ready, rsp_valid}, 2'b10);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ctl"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_we, rsp_resp, cmd_ready},
        10'b0000000_00_1 >> 0);
    chk({nm, "_data"}, {AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata}, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = mk(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h1111_1111, 0, 2'b00, 32'h0, 3);
    vecs[1] = mk(0, 32'h10, 32'h0,         4'h0, 0, 0, 0, 0, 5, 2'b00, 32'hDEAD_BEEF, 0, 2'b00, 32'hDEAD_BEEF, 8);
    vecs[2] = mk(1, 32'h24, 32'h1234_5678, 4'h3, 0, 3, 0, 0, 0, 2'b00, 32'h2222_2222, 0, 2'b00, 32'h0, 6);
    vecs[3] = mk(1, 32'h30, 32'h0BAD_F00D, 4'hC, 0, 0, 0, 0, 0, 2'b10, 32'h3333_3333, 4, 2'b10, 32'h0, 3);
    vecs[4] = mk(0, 32'h44, 32'h0,         4'h0, 0, 0, 0, 2, 1, 2'b01, 32'hA5A5_0F0F, 0, 2'b01, 32'hA5A5_0F0F, 6);
    vecs[5] = mk(1, 32'h58, 32'h8765_4321, 4'h9, 4, 1, 2, 0, 0, 2'b01, 32'h4444_4444, 1, 2'b01, 32'h0, 9);
    vecs[6] = mk(0, 32'hFFFF_FFFC, 32'h0,  4'h0, 0, 0, 0, 0, 0, 2'b10, 32'hFFFF_FFFF, 0, 2'b10, 32'hFFFF_FFFF, 3);

    mon_off = 1;
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
    BRESP = 0; RRESP = 0; RDATA = 0;
    set_slave(vecs[0]);
    ARESET = 1;
    repeat (3) @(negedge ACLK);
    chk_reset_vals("reset");
    ARESET = 0;
    @(negedge ACLK);
    mon_off = 0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while WR_RESP waits on a slow BVALID
    begin
      vec_t w;
      int   n;
      w = mk(1, 32'h50, 32'hCAFE_F00D, 4'hF, 0, 0, 50, 0, 0, 2'b00, 32'h0, 0, 2'b00, 32'h0, 0);
      set_slave(w);
      cmd_valid = 1; cmd_we = 1; cmd_addr = w.addr; cmd_wdata = w.wdata; cmd_wstrb = w.wstrb;
      @(negedge ACLK);
      cmd_valid = 0;
      n = 0;
      while (!BREADY && n < 20) begin @(negedge ACLK); n++; end
      chk("rst_mid_bready", BREADY, 1);
      @(negedge ACLK);
      mon_off = 1;
      ARESET = 1;
      @(negedge ACLK);
      ARESET = 0;
      chk_reset_vals("rst_mid");
      @(negedge ACLK);
      mon_off = 0;
      run_vec(mk(0, 32'h50, 32'h0, 4'h0, 1, 0, 0, 1, 2, 2'b00, 32'h0123_4567, 0, 2'b00, 32'h0123_4567, 6),
              "post_rst_rd");
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    mon_off = 1;
    run_vec(mk(0, 32'h60, 32'h0, 4'h0, 0, 0, 0, 100000, 0, 2'b00, 32'h9999_9999, 0, 2'b11, 32'h0, 17),
            "timeout");
    @(negedge ACLK);
    mon_off = 0;
    chk("timeout_arvalid", ARVALID, 0);
`endif

    chk("sb_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
